// File: rtl/crc5_pkg.sv
// -----------------------------------------------------------------------------
// crc5_pkg
// Shared definitions for the 2-bit-per-cycle CRC-5 datapath.
// Generator g(y) = 1 + y + y^3 + y^5.
//   CRC_W     : width of the CRC remainder
//   POLY      : feedback tap mask (y^5 term implicit)
//   state_t   : controller FSM states
//   crc5_step : one serial (1-bit) CRC update, MSB-first
// -----------------------------------------------------------------------------
package crc5_pkg;

    localparam int CRC_W = 5;
    localparam logic [CRC_W-1:0] POLY = 5'b01011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift left by one and fold the feedback bit into the tap positions
    // (y^0, y^1, y^3). The result after a full message is M(y)*y^5 mod g(y).
    function automatic logic [CRC_W-1:0] crc5_step(input logic d,
                                                   input logic [CRC_W-1:0] c);
        logic fb;
        fb = d ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY);
    endfunction

endpackage

// File: rtl/crc5_unfold2_ctrl_if.sv
// -----------------------------------------------------------------------------
// crc5_unfold2_ctrl_if
// Message-in / CRC-out handshake bundle for crc5_unfold2_ctrl.
//   in_valid / in_ready / in_data    : message input handshake
//   out_valid / out_ready / out_crc  : CRC result handshake
// Modports:
//   master : source/consumer side (drives in_*, out_ready)
//   slave  : the CRC controller side
// -----------------------------------------------------------------------------
interface crc5_unfold2_ctrl_if
    import crc5_pkg::*;
#(
    parameter int MSG_W = 6
) ();

    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CRC_W-1:0] out_crc;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_crc
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_crc
    );

endinterface

// File: rtl/crc5_unfold2_core.sv
// -----------------------------------------------------------------------------
// crc5_unfold2_core
// CRC-5 state register unfolded by 2: two serial steps per enabled cycle.
//   clk    : clock
//   reset  : asynchronous active-high reset, clears the CRC state
//   clr    : synchronous clear (takes priority over en)
//   en     : apply two serial steps this cycle
//   d_pair : input bits, d_pair[1] processed first
//   crc    : current CRC state
// -----------------------------------------------------------------------------
module crc5_unfold2_core
    import crc5_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       d_pair,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_mid;
    logic [CRC_W-1:0] crc_next;

    always_comb begin
        crc_mid  = crc5_step(d_pair[1], crc);
        crc_next = crc5_step(d_pair[0], crc_mid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/crc5_unfold2_ctrl.sv
// -----------------------------------------------------------------------------
// crc5_unfold2_ctrl
// Sequencer around crc5_unfold2_core: accepts a whole message, feeds it MSB
// first two bits per cycle, and presents the finished CRC-5.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : message/CRC handshake bundle (slave side)
//   busy  : high while a message is in RUN or DONE
// Timing: load cycle + MSG_W/2 RUN cycles, then DONE until out_ready.
// -----------------------------------------------------------------------------
module crc5_unfold2_ctrl
    import crc5_pkg::*;
#(
    parameter int MSG_W = 6,
    parameter int CNT_W = $clog2(MSG_W/2) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    crc5_unfold2_ctrl_if.slave   bus,
    output logic                 busy
);

    if ((MSG_W < 2) || ((MSG_W % 2) != 0)) begin : g_bad_msg_w
        $error("crc5_unfold2_ctrl: MSG_W must be even and >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MSG_W/2 - 1);

    state_t           state;
    state_t           state_next;
    logic [MSG_W-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_hold;
    logic             accept;
    logic             crc_clr;
    logic             crc_en;

    crc5_unfold2_core u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .d_pair (sreg[MSG_W-1 -: 2]),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    crc_clr    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                crc_en = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            cnt      <= '0;
            crc_hold <= '0;
        end else begin
            if (accept) begin
                sreg <= bus.in_data;
                cnt  <= CNT_LOAD;
            end else if (state == RUN) begin
                sreg <= {sreg[MSG_W-3:0], 2'b00};
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
            // The core state is cleared on the next accept, so keep a copy
            // that lets out_crc retain the last result after the handshake.
            if (state == DONE) begin
                crc_hold <= crc;
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_crc   = (state == DONE) ? crc : crc_hold;
        busy          = (state == RUN) || (state == DONE);
    end

endmodule

// File: tb/tb_crc5_unfold2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crc5_unfold2_ctrl
// Scoreboard bench for crc5_unfold2_ctrl: the driver pushes the expected CRC
// and accept cycle on each handshake; a monitor checks every result the DUT
// presents, including latency, stability under stall and pulse width.
// -----------------------------------------------------------------------------
module tb_crc5_unfold2_ctrl;
    import crc5_pkg::*;

    localparam int MSG_W = 6;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc5_unfold2_ctrl_if #(.MSG_W(MSG_W)) bus ();

    crc5_unfold2_ctrl #(.MSG_W(MSG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic [4:0] crc;
        int         issue;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Polynomial long division of M(y)*y^5 by g(y) = y^5+y^3+y+1.
    function automatic logic [4:0] ref_crc(input logic [5:0] m);
        logic [10:0] r;
        r = {m, 5'b00000};
        for (int i = 10; i >= 5; i--) begin
            if (r[i]) r[i -: 6] = r[i -: 6] ^ 6'b101011;
        end
        return r[4:0];
    endfunction

    // Monitor: samples on the falling edge.
    logic       prev_hs = 1'b0;
    logic       prev_pend = 1'b0;
    logic [4:0] held = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_hs   = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_hs) check("pulse_end", bus.out_valid, 1'b0);
            if (bus.out_valid) begin
                check("in_ready_in_done", bus.in_ready, 1'b0);
                check("busy_in_done", busy, 1'b1);
                if (!prev_pend) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: actual out_crc=%0h required=no output", bus.out_crc);
                    end else begin
                        check("out_crc", bus.out_crc, exp_q[0].crc);
                        check("latency", cyc - exp_q[0].issue, 4);
                        held = bus.out_crc;
                    end
                end else begin
                    check("stall_stable_crc", bus.out_crc, held);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    stall_cnt++;
                end
            end
            prev_hs   = bus.out_valid && bus.out_ready;
            prev_pend = bus.out_valid && !bus.out_ready;
        end
    end

    // Driver: called at posedge+1. Holds in_valid until the block is in IDLE.
    task automatic send(input logic [5:0] d, input logic [4:0] exp_crc, input bit expect_out);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: actual in_ready=0 required=1 for data %b", d);
            bus.in_valid = 1'b0;
        end else begin
            if (expect_out) exp_q.push_back('{crc: exp_crc, issue: cyc});
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] perm [64];
        int         stall_base;
        int         w;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_crc", bus.out_crc, 5'b00000);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed remainders.
        send(6'b000000, 5'b00000, 1'b1); drain();
        send(6'b000001, 5'b01011, 1'b1); drain();
        send(6'b100000, 5'b10011, 1'b1); drain();
        send(6'b000011, 5'b11101, 1'b1); drain();
        check("crc_retained_after_hs", bus.out_crc, 5'b11101);

        // Two messages with a 5-cycle consumer stall on the first.
        bus.out_ready = 1'b0;
        send(6'b000001, 5'b01011, 1'b1);
        stall_base = stall_cnt;
        fork
            send(6'b100000, 5'b10011, 1'b1);
            begin
                w = 0;
                while (!bus.out_valid && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                check("stall_valid_seen", bus.out_valid, 1'b1);
                repeat (5) begin
                    @(posedge clk); #1;
                end
                check("stall_valid_held", bus.out_valid, 1'b1);
                check("stall_in_ready_low", bus.in_ready, 1'b0);
                check("stall_crc_held", bus.out_crc, 5'b01011);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", (stall_cnt - stall_base) >= 5, 1'b1);

        // Reset during the second RUN cycle aborts the message.
        send(6'b100000, 5'b10011, 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_crc", bus.out_crc, 5'b00000);
        @(posedge clk); #1;
        reset = 1'b0;
        send(6'b000001, 5'b01011, 1'b1);
        drain();

        // Sweep of all 64 messages in shuffled order against the model.
        for (int i = 0; i < 64; i++) perm[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            int         j;
            logic [5:0] t;
            j       = $urandom_range(i, 0);
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            send(perm[i], ref_crc(perm[i]), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
